// File: rtl/ola_trigger_sequencer.sv
// ---------------------------------------------------------------------------
// ola_trigger_sequencer : four-stage masked-compare trigger sequencer with a
// one-cycle sample pass-through.                            Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ola_trigger_sequencer #(
  parameter int width = 8,
  parameter int cntw  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [width-1:0] in_sample,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_stage,
  input  logic [width-1:0] cfg_mask,
  input  logic [width-1:0] cfg_value,
  input  logic [cntw-1:0]  cfg_count,
  input  logic [1:0]       cfg_last,
  input  logic             arm,
  input  logic             disarm,
  output logic             out_valid,
  output logic [width-1:0] out_sample,
  output logic             out_trigger,
  output logic             armed,
  output logic             fired,
  output logic [1:0]       cur_stage
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIRED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       stage_q, stage_d;
  logic [1:0]       last_q, last_d;
  logic [cntw-1:0]  hits_q, hits_d;
  logic [width-1:0] mask_q  [0:3];
  logic [width-1:0] mask_d  [0:3];
  logic [width-1:0] value_q [0:3];
  logic [width-1:0] value_d [0:3];
  logic [cntw-1:0]  count_q [0:3];
  logic [cntw-1:0]  count_d [0:3];
  logic             out_valid_q, out_valid_d;
  logic [width-1:0] out_sample_q, out_sample_d;
  logic             out_trigger_q, out_trigger_d;

  logic             w_match;
  logic [cntw-1:0]  w_need;
  logic [cntw:0]    w_hits_inc;
  logic             w_stage_done;

  assign w_match      = ((in_sample ^ value_q[stage_q]) & mask_q[stage_q]) == '0;
  assign w_need       = (count_q[stage_q] == '0) ? cntw'(1) : count_q[stage_q];
  // One extra bit so hits+1 never wraps, even against a count of 2^cntw-1.
  assign w_hits_inc   = {1'b0, hits_q} + {{cntw{1'b0}}, 1'b1};
  assign w_stage_done = w_hits_inc >= {1'b0, w_need};

  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    last_d        = last_q;
    hits_d        = hits_q;
    out_valid_d   = in_valid;
    out_sample_d  = in_sample;
    out_trigger_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mask_d[i]  = mask_q[i];
      value_d[i] = value_q[i];
      count_d[i] = count_q[i];
    end

    // Stage writes land next cycle, so the compare below uses the old values.
    if (cfg_we) begin
      mask_d[cfg_stage]  = cfg_mask;
      value_d[cfg_stage] = cfg_value;
      count_d[cfg_stage] = cfg_count;
    end

    if (disarm) begin
      state_d = IDLE;
      stage_d = 2'd0;
      hits_d  = '0;
    end else if (arm && (state_q != RUN)) begin
      state_d = RUN;
      stage_d = 2'd0;
      hits_d  = '0;
      last_d  = cfg_last;
    end else if ((state_q == RUN) && in_valid) begin
      if (!w_match) begin
        hits_d = '0;
      end else if (!w_stage_done) begin
        hits_d = w_hits_inc[cntw-1:0];
      end else if (stage_q != last_q) begin
        stage_d = stage_q + 2'd1;
        hits_d  = '0;
      end else begin
        state_d       = FIRED;
        hits_d        = '0;
        out_trigger_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      stage_q       <= 2'd0;
      last_q        <= 2'd0;
      hits_q        <= '0;
      out_valid_q   <= 1'b0;
      out_sample_q  <= '0;
      out_trigger_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mask_q[i]  <= '0;
        value_q[i] <= '0;
        count_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      last_q        <= last_d;
      hits_q        <= hits_d;
      out_valid_q   <= out_valid_d;
      out_sample_q  <= out_sample_d;
      out_trigger_q <= out_trigger_d;
      for (int i = 0; i < 4; i++) begin
        mask_q[i]  <= mask_d[i];
        value_q[i] <= value_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sample  = out_sample_q;
  assign out_trigger = out_trigger_q;
  assign armed       = (state_q == RUN);
  assign fired       = (state_q == FIRED);
  assign cur_stage   = stage_q;

endmodule

`default_nettype wire
